// File: rtl/mbist_pkg.sv
// Shared types and constants for the March Y MBIST controller.
// States, op-index encodings and per-element op counts.
package mbist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    M0,
    M1,
    M2,
    M3,
    FLUSH,
    DONE
  } state_t;

  localparam logic [1:0] OP_0 = 2'd0;
  localparam logic [1:0] OP_1 = 2'd1;
  localparam logic [1:0] OP_2 = 2'd2;

  localparam int unsigned M0_OPS = 16;
  localparam int unsigned M1_OPS = 48;
  localparam int unsigned M2_OPS = 48;
  localparam int unsigned M3_OPS = 16;

  localparam int unsigned TOTAL_OPS =
    M0_OPS + M1_OPS + M2_OPS + M3_OPS;

endpackage

// File: rtl/mbist_addr_gen.sv
// Up/down address counter for the march elements.
// load presets to all-zeros or all-ones; tc flags the end address.
module mbist_addr_gen #(
  parameter int AWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              ld_hi,
  input  logic              en,
  input  logic              dir,
  output logic [AWIDTH-1:0] addr,
  output logic              tc
);

  // counter: load wins over count; dir=1 counts down
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
    end else if (load) begin
      addr <= ld_hi ? '1 : '0;
    end else if (en) begin
      addr <= dir ? addr - 1'b1 : addr + 1'b1;
    end
  end

  assign tc = dir ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/mbist_march_y_ctrl.sv
// March Y MBIST controller: sequences the memory ports and checks reads.
// Define MBIST_DIAG_EN to keep first-fail capture and the mismatch count.
module mbist_march_y_ctrl
  import mbist_pkg::*;
#(
  parameter int              AWIDTH  = 4,
  parameter int              DWIDTH  = 8,
  parameter logic [DWIDTH-1:0] DATA_BG = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [AWIDTH-1:0] fail_addr,
  output logic [DWIDTH-1:0] fail_exp,
  output logic [DWIDTH-1:0] fail_act,
  output logic [7:0]        fail_cnt,
  output logic [AWIDTH-1:0] mem_ca,
  output logic              mem_we,
  output logic [DWIDTH-1:0] mem_datain,
  output logic              mem_re,
  input  logic [DWIDTH-1:0] mem_dataout
);

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic                ag_load, ag_hi, ag_en, ag_dir;
  logic [AWIDTH-1:0]   addr;
  logic                tc;
  logic                start_ok;
  logic [DWIDTH-1:0]   exp_d, exp_q;
  logic                rd_q;
  logic                mism;
  logic                fail_q;

  assign start_ok = start &&
    (state_q == IDLE || state_q == DONE);

  mbist_addr_gen #(.AWIDTH(AWIDTH)) u_addr (
    .clk   (clk),
    .rst   (rst),
    .load  (ag_load),
    .ld_hi (ag_hi),
    .en    (ag_en),
    .dir   (ag_dir),
    .addr  (addr),
    .tc    (tc)
  );

  // state and op-index registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // next state, op stepping and address counter control
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ag_load = 1'b0;
    ag_hi   = 1'b0;
    ag_en   = 1'b0;
    ag_dir  = (state_q == M2);
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = M0;
          op_d    = OP_0;
          ag_load = 1'b1;
        end
      end
      M0: begin
        if (tc) begin
          state_d = M1;
          ag_load = 1'b1;
        end else begin
          ag_en = 1'b1;
        end
      end
      M1: begin
        if (op_q == OP_2) begin
          op_d = OP_0;
          if (tc) begin
            state_d = M2;
            ag_load = 1'b1;
            ag_hi   = 1'b1;
          end else begin
            ag_en = 1'b1;
          end
        end else begin
          op_d = op_q + 2'd1;
        end
      end
      M2: begin
        if (op_q == OP_2) begin
          op_d = OP_0;
          if (tc) begin
            state_d = M3;
            ag_load = 1'b1;
          end else begin
            ag_en = 1'b1;
          end
        end else begin
          op_d = op_q + 2'd1;
        end
      end
      M3: begin
        if (tc) begin
          state_d = FLUSH;
          ag_load = 1'b1;
        end else begin
          ag_en = 1'b1;
        end
      end
      FLUSH: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // memory port and expected-data decode from registered state
  always_comb begin
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_datain = '0;
    exp_d      = '0;
    unique case (1'b1)
      (state_q == M0): begin
        mem_we = 1'b1;
      end
      (state_q == M1): begin
        if (op_q == OP_1) begin
          mem_we     = 1'b1;
          mem_datain = DATA_BG;
        end else begin
          mem_re = 1'b1;
          exp_d  = (op_q == OP_0) ? '0 : DATA_BG;
        end
      end
      (state_q == M2): begin
        if (op_q == OP_1) begin
          mem_we = 1'b1;
        end else begin
          mem_re = 1'b1;
          exp_d  = (op_q == OP_0) ? DATA_BG : '0;
        end
      end
      (state_q == M3): begin
        mem_re = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_ca = addr;
  assign busy   = state_q inside {M0, M1, M2, M3, FLUSH};
  assign done   = (state_q == DONE);

  // remember each read's expected value for next-cycle compare
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= 1'b0;
      exp_q <= '0;
    end else begin
      rd_q  <= mem_re;
      exp_q <= exp_d;
    end
  end

  assign mism = rd_q && (mem_dataout != exp_q);

  // sticky fail flag, cleared by an accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      fail_q <= 1'b0;
    end else if (start_ok) begin
      fail_q <= 1'b0;
    end else if (mism) begin
      fail_q <= 1'b1;
    end
  end

  assign fail = fail_q;

`ifdef MBIST_DIAG_EN
  logic [AWIDTH-1:0] raddr_q;
  logic [AWIDTH-1:0] faddr_q;
  logic [DWIDTH-1:0] fexp_q, fact_q;
  logic [7:0]        fcnt_q;

  // address of the read under compare
  always_ff @(posedge clk) begin
    if (rst) begin
      raddr_q <= '0;
    end else if (mem_re) begin
      raddr_q <= addr;
    end
  end

  // first-fail capture and saturating mismatch count
  always_ff @(posedge clk) begin
    if (rst) begin
      faddr_q <= '0;
      fexp_q  <= '0;
      fact_q  <= '0;
      fcnt_q  <= '0;
    end else if (start_ok) begin
      faddr_q <= '0;
      fexp_q  <= '0;
      fact_q  <= '0;
      fcnt_q  <= '0;
    end else if (mism) begin
      if (!fail_q) begin
        faddr_q <= raddr_q;
        fexp_q  <= exp_q;
        fact_q  <= mem_dataout;
      end
      if (fcnt_q != 8'hFF) begin
        fcnt_q <= fcnt_q + 8'd1;
      end
    end
  end

  assign fail_addr = faddr_q;
  assign fail_exp  = fexp_q;
  assign fail_act  = fact_q;
  assign fail_cnt  = fcnt_q;
`else
  assign fail_addr = '0;
  assign fail_exp  = '0;
  assign fail_act  = '0;
  assign fail_cnt  = '0;
`endif

endmodule

// File: tb/tb_mbist_march_y_ctrl.sv
// Bench for mbist_march_y_ctrl with a 16x8 sync-read memory model.
// Op sequence is scoreboarded; stuck-at faults injected on read.
module tb_mbist_march_y_ctrl;

  typedef struct packed {
    logic       we;
    logic       re;
    logic [3:0] a;
    logic [7:0] d;
  } op_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, fail;
  logic [3:0] fail_addr;
  logic [7:0] fail_exp, fail_act, fail_cnt;
  logic [3:0] mem_ca;
  logic       mem_we, mem_re;
  logic [7:0] mem_datain;
  logic [7:0] mem_dataout = 8'h00;

  logic [7:0] mem [16];
  logic [3:0] sa1_a = 4'd0;
  logic [7:0] sa1_m = 8'h00;
  logic [3:0] sa0_a = 4'd0;
  logic [7:0] sa0_m = 8'h00;

  op_t q[$];
  int  n_tests = 0;
  int  n_fail = 0;

  always #5 clk = ~clk;

  mbist_march_y_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .fail        (fail),
    .fail_addr   (fail_addr),
    .fail_exp    (fail_exp),
    .fail_act    (fail_act),
    .fail_cnt    (fail_cnt),
    .mem_ca      (mem_ca),
    .mem_we      (mem_we),
    .mem_datain  (mem_datain),
    .mem_re      (mem_re),
    .mem_dataout (mem_dataout)
  );

  function automatic logic [7:0] flt(input logic [7:0] d,
                                     input logic [3:0] a);
    logic [7:0] r;
    r = d;
    if (a == sa1_a) r = r | sa1_m;
    if (a == sa0_a) r = r & ~sa0_m;
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_we) mem[mem_ca] <= mem_datain;
    if (mem_re) mem_dataout <= flt(mem[mem_ca], mem_ca);
  end

  task automatic build_ops();
    q.delete();
    for (int a = 0; a < 16; a++)
      q.push_back('{1'b1, 1'b0, 4'(a), 8'h00});
    for (int a = 0; a < 16; a++) begin
      q.push_back('{1'b0, 1'b1, 4'(a), 8'h00});
      q.push_back('{1'b1, 1'b0, 4'(a), 8'hFF});
      q.push_back('{1'b0, 1'b1, 4'(a), 8'h00});
    end
    for (int a = 15; a >= 0; a--) begin
      q.push_back('{1'b0, 1'b1, 4'(a), 8'h00});
      q.push_back('{1'b1, 1'b0, 4'(a), 8'h00});
      q.push_back('{1'b0, 1'b1, 4'(a), 8'h00});
    end
    for (int a = 0; a < 16; a++)
      q.push_back('{1'b0, 1'b1, 4'(a), 8'h00});
  endtask

  task automatic check_zero(input string nm);
    logic [48:0] v;
    v = {busy, done, fail, fail_addr, fail_exp, fail_act,
         fail_cnt, mem_ca, mem_we, mem_re, mem_datain};
    n_tests++;
    if (v !== '0) begin
      n_fail++;
      $display("FAIL %s: outputs=%h want 0", nm, v);
    end
  endtask

  task automatic pulse_start(input logic hold);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // entered 1 time unit after edge S; leaves 1 unit after S+129
  task automatic run_body(input string nm, input logic e_fail,
                          input logic [3:0] ea, input logic [7:0] ee,
                          input logic [7:0] eact, input logic [7:0] ec);
    op_t e;
    int  nwe, nre;
    nwe = 0;
    nre = 0;
    build_ops();
`ifndef MBIST_DIAG_EN
    ea = '0; ee = '0; eact = '0; ec = '0;
`endif
    for (int i = 0; i < 128; i++) begin
      e = q.pop_front();
      n_tests++;
      if ({mem_we, mem_re, mem_ca} !== {e.we, e.re, e.a} ||
          (e.we && mem_datain !== e.d) || busy !== 1'b1 ||
          done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s op%0d: we=%b re=%b ca=%0d din=%h busy=%b, want we=%b re=%b ca=%0d din=%h busy=1",
                 nm, i, mem_we, mem_re, mem_ca, mem_datain, busy,
                 e.we, e.re, e.a, e.d);
      end
      nwe += int'(mem_we);
      nre += int'(mem_re);
      @(posedge clk);
      #1;
    end
    n_tests++;
    if ({busy, done, mem_we, mem_re} !== 4'b1000) begin
      n_fail++;
      $display("FAIL %s flush: busy/done/we/re=%b want 1000",
               nm, {busy, done, mem_we, mem_re});
    end
    n_tests++;
    if (nwe != 48 || nre != 80) begin
      n_fail++;
      $display("FAIL %s opcount: we=%0d re=%0d want 48 80",
               nm, nwe, nre);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s done: busy=%b done=%b want 0 1",
               nm, busy, done);
    end
    n_tests++;
    if (fail !== e_fail) begin
      n_fail++;
      $display("FAIL %s fail: got %b want %b", nm, fail, e_fail);
    end
    n_tests++;
    if ({fail_addr, fail_exp, fail_act, fail_cnt} !==
        {ea, ee, eact, ec}) begin
      n_fail++;
      $display("FAIL %s diag: addr=%0d exp=%h act=%h cnt=%0d want %0d %h %h %0d",
               nm, fail_addr, fail_exp, fail_act, fail_cnt,
               ea, ee, eact, ec);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_zero("idle");
  endtask

  task automatic test_clean();
    pulse_start(1'b0);
    run_body("clean", 1'b0, 4'd0, 8'h00, 8'h00, 8'd0);
  endtask

  task automatic test_sa1();
    sa1_a = 4'd5;
    sa1_m = 8'h01;
    pulse_start(1'b0);
    run_body("sa1", 1'b1, 4'd5, 8'h00, 8'h01, 8'd3);
    sa1_m = 8'h00;
  endtask

  task automatic test_sa0();
    sa0_a = 4'd15;
    sa0_m = 8'h80;
    pulse_start(1'b0);
    run_body("sa0", 1'b1, 4'd15, 8'hFF, 8'h7F, 8'd2);
    sa0_m = 8'h00;
  endtask

  task automatic test_mid_reset();
    pulse_start(1'b0);
    repeat (40) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_zero("midrst");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_zero("midrst_idle");
    pulse_start(1'b0);
    run_body("after_rst", 1'b0, 4'd0, 8'h00, 8'h00, 8'd0);
  endtask

  task automatic test_start_held();
    sa1_a = 4'd5;
    sa1_m = 8'h01;
    pulse_start(1'b1);
    run_body("held1", 1'b1, 4'd5, 8'h00, 8'h01, 8'd3);
    sa1_m = 8'h00;
    @(posedge clk);
    #1;
    n_tests++;
    if ({busy, done, fail, fail_cnt, mem_we, mem_ca} !==
        {1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 4'd0}) begin
      n_fail++;
      $display("FAIL restart: busy=%b done=%b fail=%b cnt=%0d we=%b ca=%0d want 1 0 0 0 1 0",
               busy, done, fail, fail_cnt, mem_we, mem_ca);
    end
    start = 1'b0;
    run_body("held2", 1'b0, 4'd0, 8'h00, 8'h00, 8'd0);
    @(posedge clk);
    #1;
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_hold: done=%b busy=%b want 1 0",
               done, busy);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_sa1();
    test_sa0();
    test_mid_reset();
    test_start_held();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
